// File: rtl/charlieplex_pwm_scheduler.sv
// Charlieplexer scan scheduler: double-buffered brightness framebuffer, per-pixel dead-time then PWM on-phase.
// Define CHARLIEPLEX_GAMMA_EN for a squared (b*b/P) brightness curve; the default build is linear.
module charlieplex_pwm_scheduler #(
    parameter int PIXELCOUNT = 12,
    parameter int BRIGHTBITS = 4,
    parameter int DEADCYCLES = 2,
    localparam int INDEXBITS = $clog2(PIXELCOUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [INDEXBITS-1:0]  wr_addr,
    input  logic [BRIGHTBITS-1:0] wr_data,
    input  logic                  swap_req,
    output logic                  swap_done,
    output logic                  frame_start,
    output logic [INDEXBITS-1:0]  led_index,
    output logic                  led_enable
);

    // state  | meaning
    // S_IDLE | scan stopped, LEDs dark; pending swap executes here
    // S_DEAD | all pins tristated before the pixel's on-phase
    // S_ON   | PWM on-phase for pixel pix

    localparam int P       = (1 << BRIGHTBITS) - 1;
    localparam int DEADW   = $clog2(DEADCYCLES + 1);
    localparam int CNTBITS = (BRIGHTBITS > DEADW) ? BRIGHTBITS : DEADW;

    localparam logic [CNTBITS-1:0]   DEAD_LAST = CNTBITS'(DEADCYCLES - 1);
    localparam logic [CNTBITS-1:0]   ON_LAST   = CNTBITS'(P - 1);
    localparam logic [INDEXBITS-1:0] PIX_LAST  = INDEXBITS'(PIXELCOUNT - 1);

    typedef enum logic [1:0] {S_IDLE, S_DEAD, S_ON} state_t;

    state_t                state, state_n;
    logic [INDEXBITS-1:0]  pix, pix_n;
    logic [CNTBITS-1:0]    cnt, cnt_n;
    logic                  bank;
    logic                  swap_pending;
    logic                  load_on;
    logic                  flip_now;
    logic [BRIGHTBITS-1:0] ontime_q;
    logic [BRIGHTBITS-1:0] front_val;
    logic [BRIGHTBITS-1:0] fb [2][PIXELCOUNT];

`ifdef CHARLIEPLEX_GAMMA_EN
    function automatic logic [BRIGHTBITS-1:0] ontime(input logic [BRIGHTBITS-1:0] b);
        logic [2*BRIGHTBITS-1:0] sq;
        sq = {{BRIGHTBITS{1'b0}}, b} * {{BRIGHTBITS{1'b0}}, b};
        return BRIGHTBITS'(sq / (2*BRIGHTBITS)'(P));
    endfunction
`else
    function automatic logic [BRIGHTBITS-1:0] ontime(input logic [BRIGHTBITS-1:0] b);
        return b;
    endfunction
`endif

    assign front_val = fb[bank][pix];

    // The flip lands on the frame-boundary edge, or immediately while idle.
    assign flip_now = swap_pending &&
                      ((state == S_IDLE) ||
                       (state == S_ON && pix == PIX_LAST && cnt == ON_LAST));

    always_comb begin
        state_n = state;
        pix_n   = pix;
        cnt_n   = cnt;
        load_on = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    state_n = S_DEAD;
                    pix_n   = '0;
                    cnt_n   = '0;
                end
            end
            S_DEAD: begin
                if (!enable) begin
                    state_n = S_IDLE;
                    pix_n   = '0;
                    cnt_n   = '0;
                end else if (cnt == DEAD_LAST) begin
                    state_n = S_ON;
                    cnt_n   = '0;
                    load_on = 1'b1;
                end else begin
                    cnt_n = cnt + CNTBITS'(1);
                end
            end
            S_ON: begin
                if (!enable) begin
                    state_n = S_IDLE;
                    pix_n   = '0;
                    cnt_n   = '0;
                end else if (cnt == ON_LAST) begin
                    state_n = S_DEAD;
                    cnt_n   = '0;
                    pix_n   = (pix == PIX_LAST) ? '0 : pix + INDEXBITS'(1);
                end else begin
                    cnt_n = cnt + CNTBITS'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                pix_n   = '0;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pix          <= '0;
            cnt          <= '0;
            bank         <= 1'b0;
            swap_pending <= 1'b0;
            ontime_q     <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < PIXELCOUNT; i++) begin
                    fb[b][i] <= '0;
                end
            end
        end else begin
            state <= state_n;
            pix   <= pix_n;
            cnt   <= cnt_n;
            if (load_on) begin
                ontime_q <= ontime(front_val);
            end
            if (flip_now) begin
                bank <= ~bank;
            end
            // A request coinciding with the flip survives for the next frame.
            swap_pending <= swap_req | (swap_pending & ~flip_now);
            if (wr_valid && wr_ready && (32'(wr_addr) < PIXELCOUNT)) begin
                fb[~bank][wr_addr] <= wr_data;
            end
        end
    end

    assign led_index   = pix;
    assign led_enable  = (state == S_ON) && (cnt < CNTBITS'(ontime_q));
    assign frame_start = (state == S_DEAD) && (pix == '0) && (cnt == '0);
    assign swap_done   = flip_now;
    assign wr_ready    = ~flip_now;

endmodule

// File: tb/tb_charlieplex_pwm_scheduler.sv
// Directed bench for charlieplex_pwm_scheduler: table of write/swap vectors plus hand sequences.
// Expected on-times follow CHARLIEPLEX_GAMMA_EN when it is defined.
module tb_charlieplex_pwm_scheduler;

    localparam int NPIX = 12;
    localparam int DEAD = 2;
    localparam int S    = 17;
    localparam int F    = NPIX * S;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] wr_addr;
    logic [3:0] wr_data;
    logic       swap_req;
    logic       swap_done;
    logic       frame_start;
    logic [3:0] led_index;
    logic       led_enable;

    int checks = 0;
    int errors = 0;
    int exp_front [NPIX];
    int exp_back  [NPIX];
    int on_cnt    [NPIX];

    typedef struct {
        int addr;
        int data;
        bit swap;
        int chk_pix;
        int chk_bright;
    } vec_t;

    vec_t vt [7];

    charlieplex_pwm_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .swap_req    (swap_req),
        .swap_done   (swap_done),
        .frame_start (frame_start),
        .led_index   (led_index),
        .led_enable  (led_enable)
    );

    always #5 clk = ~clk;

    function automatic int ont(input int b);
`ifdef CHARLIEPLEX_GAMMA_EN
        return (b * b) / 15;
`else
        return b;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_swap();
        for (int i = 0; i < NPIX; i++) begin
            int t;
            t            = exp_front[i];
            exp_front[i] = exp_back[i];
            exp_back[i]  = t;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NPIX; i++) begin
            exp_front[i] = 0;
            exp_back[i]  = 0;
        end
    endtask

    // Entered on the sample where frame_start is high; leaves on the next frame's first sample.
    task automatic measure_frame(input bit exp_swap);
        int bad;
        int first_bad;
        bad       = 0;
        first_bad = -1;
        for (int i = 0; i < NPIX; i++) on_cnt[i] = 0;
        for (int c = 0; c < F; c++) begin
            int p;
            int ph;
            bit e_en;
            bit e_fs;
            bit e_sd;
            p    = c / S;
            ph   = c % S;
            e_en = (ph >= DEAD) && ((ph - DEAD) < ont(exp_front[p]));
            e_fs = (c == 0);
            e_sd = exp_swap && (c == F - 1);
            if (led_enable && int'(led_index) < NPIX) on_cnt[led_index]++;
            if (int'(led_index) != p || led_enable != e_en || frame_start != e_fs ||
                swap_done != e_sd || wr_ready != !e_sd) begin
                bad++;
                if (first_bad < 0) first_bad = c;
            end
            @(negedge clk);
        end
        if (bad > 0) $display("  note: first differing scan cycle %0d", first_bad);
        check("frame_scan_bad_cycles", bad, 0);
        check("frame_period_start", int'(frame_start), 1);
    endtask

    task automatic wait_frame_start();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 2 * F);
        check("wait_frame_start", int'(frame_start), 1);
    endtask

    task automatic wait_swap_done();
        int n;
        n = 0;
        while (!swap_done && n < 2 * F) begin
            @(negedge clk);
            n++;
        end
        check("swap_done_seen", int'(swap_done), 1);
        check("wr_ready_at_flip", int'(wr_ready), 0);
        check("flip_at_last_pixel", int'(led_index), NPIX - 1);
        model_swap();
    endtask

    task automatic pulse_swap();
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
    endtask

    task automatic do_write(input int a, input int d, output int stalls);
        stalls   = 0;
        wr_valid = 1'b1;
        wr_addr  = 4'(a);
        wr_data  = 4'(d);
        for (int k = 0; k < 8; k++) begin
            if (wr_ready) break;
            stalls++;
            @(negedge clk);
        end
        check("write_accepted", int'(wr_ready), 1);
        if (wr_ready && a < NPIX) exp_back[a] = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int n;
        int bad;

        vt[0] = '{3, 15, 1'b0, 3, 0};
        vt[1] = '{5, 7, 1'b1, 3, 15};
        vt[2] = '{0, 9, 1'b0, 0, 0};
        vt[3] = '{13, 5, 1'b1, 0, 9};
        vt[4] = '{11, 15, 1'b1, 11, 15};
        vt[5] = '{2, 1, 1'b1, 2, 1};
        vt[6] = '{3, 0, 1'b1, 3, 0};

        rst      = 1'b1;
        enable   = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        swap_req = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);

        check("reset_led_index", int'(led_index), 0);
        check("reset_led_enable", int'(led_enable), 0);
        check("reset_wr_ready", int'(wr_ready), 1);
        check("reset_frame_start", int'(frame_start), 0);
        check("reset_swap_done", int'(swap_done), 0);

        rst    = 1'b0;
        enable = 1'b1;
        wait_frame_start();
        measure_frame(1'b0);
        measure_frame(1'b0);

        for (int v = 0; v < 7; v++) begin
            do_write(vt[v].addr, vt[v].data, st);
            if (vt[v].swap) begin
                pulse_swap();
                wait_swap_done();
                @(negedge clk);
                check("boundary_frame_start", int'(frame_start), 1);
            end else begin
                wait_frame_start();
            end
            measure_frame(1'b0);
            check($sformatf("vec%0d_pix%0d_on", v, vt[v].chk_pix),
                  on_cnt[vt[v].chk_pix], ont(vt[v].chk_bright));
        end

        // Merged requests give one flip; a request on the flip cycle gives a second one.
        do_write(6, 12, st);
        pulse_swap();
        @(negedge clk);
        pulse_swap();
        wait_swap_done();
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        check("req_on_flip_frame_start", int'(frame_start), 1);
        measure_frame(1'b1);
        model_swap();
        measure_frame(1'b0);

        // Drop enable during pixel 6 on-phase.
        pulse_swap();
        wait_swap_done();
        @(negedge clk);
        check("pre_drop_frame_start", int'(frame_start), 1);
        repeat (6 * S + DEAD + 1) @(negedge clk);
        check("pix6_index_before_drop", int'(led_index), 6);
        check("pix6_lit_before_drop", int'(led_enable), 1);
        enable = 1'b0;
        @(negedge clk);
        check("led_enable_after_drop", int'(led_enable), 0);
        check("index_after_drop", int'(led_index), 0);
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (led_enable || frame_start) bad++;
        end
        check("idle_stays_dark", bad, 0);
        enable = 1'b1;
        @(negedge clk);
        check("restart_frame_start", int'(frame_start), 1);
        measure_frame(1'b0);

        // Swap while idle stalls a concurrent write for exactly one cycle.
        enable = 1'b0;
        @(negedge clk);
        pulse_swap();
        check("idle_swap_done", int'(swap_done), 1);
        check("idle_flip_wr_ready", int'(wr_ready), 0);
        model_swap();
        do_write(4, 10, st);
        check("idle_flip_stall_cycles", st, 1);
        check("idle_swap_done_cleared", int'(swap_done), 0);
        pulse_swap();
        check("idle_swap_done_2", int'(swap_done), 1);
        model_swap();
        @(negedge clk);
        enable = 1'b1;
        wait_frame_start();
        measure_frame(1'b0);
        check("stalled_write_pix4_on", on_cnt[4], ont(10));

        // Reset during a lit on-phase clears everything.
        n = 0;
        while (!led_enable && n < F) begin
            @(negedge clk);
            n++;
        end
        check("found_lit_cycle", int'(led_enable), 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_on_led_enable", int'(led_enable), 0);
        check("rst_mid_on_led_index", int'(led_index), 0);
        check("rst_mid_on_frame_start", int'(frame_start), 0);
        rst = 1'b0;
        model_clear();
        wait_frame_start();
        measure_frame(1'b0);
        pulse_swap();
        wait_swap_done();
        @(negedge clk);
        check("post_rst_swap_frame_start", int'(frame_start), 1);
        measure_frame(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/charlieplex_pwm_scheduler.md
Name: charlieplex_pwm_scheduler

Overview:
- Time-multiplexing scheduler that drives a charlieplexer's LED index and enable inputs.
- Holds a double-buffered per-pixel brightness framebuffer and scans pixels 0..PIXELCOUNT-1.
- Each pixel gets a dead-time slot (all pins tristated, anti-ghosting), then a PWM on-phase.
- Sits between a host write interface and the charlieplexer; replaces the fixed on/off scan with graded brightness and tear-free frame updates.

Parameters:
- PIXELCOUNT, 12, number of LEDs scanned; ≥2.
- BRIGHTBITS, 4, brightness width per pixel; PWM period P = 2^BRIGHTBITS-1 cycles.
- DEADCYCLES, 2, tristate cycles before each pixel's on-phase; ≥1.
- localparam INDEXBITS = $clog2(PIXELCOUNT); slot length S = DEADCYCLES+P; frame length F = PIXELCOUNT*S.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run scan; low forces IDLE.
- wr_valid  in  1  host write request.
- wr_ready  out  1  write accepted when wr_valid&wr_ready.
- wr_addr  in  INDEXBITS  pixel index to write.
- wr_data  in  BRIGHTBITS  brightness (0=off, P=full).
- swap_req  in  1  one-cycle pulse: present back buffer at next frame boundary.
- swap_done  out  1  one-cycle pulse on the cycle the bank flips.
- frame_start  out  1  one-cycle pulse on first DEAD cycle of pixel 0.
- led_index  out  INDEXBITS  to charlieplexer in.
- led_enable  out  1  to charlieplexer enable.

Behaviour:
- Reset values: state=IDLE, pix=0, cnt=0, bank=0, swap_pending=0, both buffers all-zero; led_index=0, led_enable=0, wr_ready=1, frame_start=0, swap_done=0.
- Outputs are decoded from registers only; no combinational input→output path.
- States: IDLE, DEAD, ON.
- IDLE: led_enable=0. If enable is sampled high, next state is DEAD with pix=0, cnt=0, and frame_start=1 during that DEAD cycle.
- DEAD: led_index=pix, led_enable=0, cnt counts 0..DEADCYCLES-1, then the state goes to ON with cnt=0.
- ON: led_index=pix, led_enable=(cnt < ontime(front[pix])), cnt counts 0..P-1.
  - At cnt=P-1, the state goes to DEAD with pix+1.
  - If pix=PIXELCOUNT-1, pix wraps to 0 (frame boundary) and frame_start pulses in the next DEAD cycle.
- ontime(b)=b without the gamma option. b=0 never lights; b=P lights all P cycles.
- enable sampled low in DEAD or ON: next cycle the state is IDLE and led_enable=0. pix, cnt and frame_start restart from pixel 0 on re-enable.
- Writes:
  - Always target the back bank (bank^1).
  - wr_addr ≥ PIXELCOUNT is accepted (handshake completes) and the data is dropped.
  - Write data is visible only after a swap.
- Swap:
  - swap_req sets swap_pending; repeated requests while pending merge into one.
  - At the frame-boundary transition (ON, pix=PIXELCOUNT-1, cnt=P-1) with swap_pending=1: bank flips, swap_pending clears, and swap_done pulses in the same cycle as the flip.
  - In IDLE, a pending swap executes on the next cycle.
- wr_ready=0 only in the cycle the flip is registered, so no write races the flip.
- swap_req arriving in the same cycle as the flip is not lost: it sets swap_pending for the following frame.
- After a flip, the new back bank holds the previous front contents. It is not cleared; the host rewrites all pixels or accepts the stale values.
- rst mid-frame returns every register to its reset value on the next edge, including clearing both buffers.

Optional Feature:
- CHARLIEPLEX_GAMMA_EN defined: ontime(b)=floor(b*b/P), using a 2*BRIGHTBITS-bit intermediate, computed on entry to ON and held for the phase. With P=15: b=1→0, b=8→4, b=15→15.
- Undefined: linear ontime(b)=b, and no multiplier is instantiated.

Test Plan (defaults PIXELCOUNT=12, BRIGHTBITS=4, DEADCYCLES=2, S=17, F=204):
- Reset, enable=1, no writes → frame_start every 204 cycles, led_enable never 1, led_index steps 0..11 every 17 cycles and wraps.
- Write pixel 3=15, pixel 5=7, then pulse swap_req → swap_done at next boundary. Next frame: pixel 3 lit 15 consecutive cycles after 2 dark cycles, pixel 5 lit 7 cycles, all others dark (linear build).
- Write pixel 0=9 without swap_req → displayed frame unchanged; after swap_req + swap_done, pixel 0 lit 9 cycles/frame.
- Hold wr_valid=1 across the flip cycle → wr_ready=0 exactly one cycle; no write lost or duplicated. Write to wr_addr=13 → accepted, no effect.
- Drop enable during pixel 6 ON → led_enable=0 the next cycle and the state is IDLE. Re-enable → frame_start, scan restarts at pixel 0.
- With CHARLIEPLEX_GAMMA_EN, front pixel 2=8 → 4 on-cycles; pixel 2=1 → 0 on-cycles; assert rst mid-ON → led_enable=0 and buffers zero on the next edge.
